serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_pkg.sv | 25 ++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/serial_transmitter.sv | 140 ++++++++++++++
 tb/tb_serial_transmitter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: FSM state codes, parity modes,
// bit-period calculation and the parity helper.
package serial_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: free-runs while clear is low and flags the last cycle of
// each CLKS_PER_BIT window, wrapping to 0 on that same edge.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_transmitter.sv
// UART-style transmitter: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits. txd comes straight from a flop.
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       txd,
  output logic       txDone
);

  localparam int   CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam logic STOP_LAST    = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $fatal(1, "serial_transmitter: illegal CLK_FREQ/BAUD, PARITY or STOP_BITS");
  end

  tx_state_t  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;

  // Counter is held at 0 while idle so the start bit gets a full period.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (txStart) begin
          data_d  = txData;
          idx_d   = 3'd0;
          state_d = ST_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          txd_d   = data_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = parity_bit(data_q, PARITY);
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd    = txd_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three configurations (8N1, 8O2, 8E2) driven by
// directed and random bytes, compared against a frame model built from the bit rules.
module tb_serial_transmitter;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_start [3];
  logic [7:0] tx_data  [3];
  logic       txd_w    [3];
  logic       busy_w   [3];
  logic       done_w   [3];

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 2, 2};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_transmitter u_dut0 (
    .clk(clk), .rstn(rstn), .txStart(tx_start[0]), .txData(tx_data[0]),
    .txBusy(busy_w[0]), .txd(txd_w[0]), .txDone(done_w[0])
  );

  serial_transmitter #(.PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .txStart(tx_start[1]), .txData(tx_data[1]),
    .txBusy(busy_w[1]), .txd(txd_w[1]), .txDone(done_w[1])
  );

  serial_transmitter #(.PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .txStart(tx_start[2]), .txData(tx_data[2]),
    .txBusy(busy_w[2]), .txd(txd_w[2]), .txDone(done_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: the line levels for each bit period, from the framing rules.
  task automatic build_frame(input int k, input logic [7:0] b, output logic bits [$]);
    int ones;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(((b >> i) & 8'd1) != 0);
    ones = $countones(b);
    if (par_cfg[k] == 1) bits.push_back((ones % 2) == 0);
    if (par_cfg[k] == 2) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < stop_cfg[k]; i++) bits.push_back(1'b1);
  endtask

  // Starts a frame on DUT k (caller is 1 time unit after a rising edge with DUT idle)
  // and follows it cycle by cycle. Optionally injects a second request mid-frame or
  // aborts with reset at a given frame cycle.
  task automatic run_frame(input int k, input logic [7:0] b, input int inject_at,
                           input logic [7:0] inj, input int abort_at);
    logic bits [$];
    int   n, cyc, bad, busy_cnt, done_seen;
    logic [7:0] dec;
    build_frame(k, b, bits);
    n = bits.size();
    busy_cnt = 0;
    done_seen = 0;
    dec = 8'h00;
    tx_start[k] = 1'b1;
    tx_data[k]  = b;
    @(posedge clk); #1;
    tx_start[k] = 1'b0;
    tx_data[k]  = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        cyc = i * CPB + c;
        if (cyc == abort_at) begin
          #2 rstn = 1'b0;
          #1;
          chk($sformatf("abort_txd dut%0d", k), 32'(txd_w[k]), 32'd1);
          chk($sformatf("abort_busy dut%0d", k), 32'(busy_w[k]), 32'd0);
          chk($sformatf("abort_done dut%0d", k), 32'(done_w[k]), 32'd0);
          for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            chk($sformatf("reset_hold_done dut%0d", k), 32'(done_w[k]), 32'd0);
          end
          rstn = 1'b1;
          $display("frame dut%0d byte %02h aborted at cycle %0d", k, b, cyc);
          return;
        end
        if (cyc == inject_at) begin
          tx_start[k] = 1'b1;
          tx_data[k]  = inj;
        end else if (cyc == inject_at + 1) begin
          tx_start[k] = 1'b0;
        end
        if (txd_w[k] !== bits[i]) bad++;
        if (busy_w[k] === 1'b1) busy_cnt++;
        if (done_w[k] !== 1'b0) done_seen++;
        if (c == CPB / 2 && i >= 1 && i <= 8) dec[i-1] = txd_w[k];
        @(posedge clk); #1;
      end
      chk($sformatf("dut%0d byte %02h bit%0d cycles_wrong", k, b, i), 32'(bad), 32'd0);
    end
    chk($sformatf("dut%0d busy_len", k), 32'(busy_cnt), 32'(n * CPB));
    chk($sformatf("dut%0d done_in_frame", k), 32'(done_seen), 32'd0);
    chk($sformatf("dut%0d decoded", k), 32'(dec), 32'(b));
    chk($sformatf("dut%0d end_busy", k), 32'(busy_w[k]), 32'd0);
    chk($sformatf("dut%0d end_done", k), 32'(done_w[k]), 32'd1);
    chk($sformatf("dut%0d end_txd", k), 32'(txd_w[k]), 32'd1);
    $display("frame dut%0d byte %02h bits %0d busy %0d decoded %02h", k, b, n, busy_cnt, dec);
  endtask

  task automatic idle_cycle(input int k);
    @(posedge clk); #1;
    chk($sformatf("dut%0d done_pulse_width", k), 32'(done_w[k]), 32'd0);
    chk($sformatf("dut%0d idle_txd", k), 32'(txd_w[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      tx_start[k] = 1'b0;
      tx_data[k]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_txd dut%0d", k), 32'(txd_w[k]), 32'd1);
      chk($sformatf("reset_busy dut%0d", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("reset_done dut%0d", k), 32'(done_w[k]), 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 8'h55, -10, 8'h00, -1);
    idle_cycle(0);
    run_frame(0, 8'hA5, 1000, 8'hFF, -1);
    idle_cycle(0);
    // Back-to-back: each request lands in the cycle where txDone is high.
    run_frame(0, 8'h00, -10, 8'h00, -1);
    run_frame(0, 8'h01, -10, 8'h00, -1);
    run_frame(0, 8'h02, -10, 8'h00, -1);
    idle_cycle(0);
    // Reset in the middle of the fifth data bit, then accept right after release.
    run_frame(0, 8'hC7, -10, 8'h00, 5 * CPB + 200);
    run_frame(0, 8'h3C, -10, 8'h00, -1);
    idle_cycle(0);
    // Command 0 from the command processor maps to byte 8'h04.
    run_frame(0, 8'h04, -10, 8'h00, -1);
    idle_cycle(0);
    for (int r = 0; r < 2; r++) begin
      run_frame(0, 8'($urandom), int'($urandom_range(50, 3000)), 8'($urandom), -1);
      idle_cycle(0);
    end

    run_frame(1, 8'h03, -10, 8'h00, -1);
    idle_cycle(1);
    run_frame(2, 8'h03, -10, 8'h00, -1);
    idle_cycle(2);
    run_frame(1, 8'($urandom), -10, 8'h00, -1);
    idle_cycle(1);
    run_frame(2, 8'($urandom), -10, 8'h00, -1);
    idle_cycle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
